// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller built around one shared 1-bit full_adder.
// Operands are consumed LSB first, one bit per clock, under a start/busy/done handshake.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] op_a, op_b, res, res_next;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s, fa_co;
  logic             accept, last_bit;

  full_adder u_fa (
    .a  (op_a[0]),
    .b  (op_b[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == RUN) && (count == LAST);
  // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
  assign res_next = (res >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : ci;
      count <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> 1;
      op_b  <= op_b >> 1;
      res   <= res_next;
      carry <= fa_co;
      count <= count + 1'b1;
      // On the MSB step, carry still holds the carry into the MSB
      if (last_bit) begin
        sum <= res_next;
        co  <= fa_co;
        ovf <= carry ^ fa_co;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl at WIDTH 8, 1 and 16 side by side.
// Expected results come from plain signed/unsigned arithmetic, checked when done pulses.

module tb_serial_adder_ctrl;

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start_v [3];
  logic        sub_v   [3];
  logic        ci_v    [3];
  logic [31:0] a_v     [3];
  logic [31:0] b_v     [3];

  logic        busy8, done8, co8, ovf8;
  logic [7:0]  sum8;
  logic        busy1, done1, co1, ovf1;
  logic [0:0]  sum1;
  logic        busy16, done16, co16, ovf16;
  logic [15:0] sum16;

  logic        busy_o [3];
  logic        done_o [3];
  logic        co_o   [3];
  logic        ovf_o  [3];
  logic [31:0] sum_o  [3];

  int   checks = 0;
  int   errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub_v[0]),
    .a(a_v[0][7:0]), .b(b_v[0][7:0]), .ci(ci_v[0]),
    .busy(busy8), .done(done8), .sum(sum8), .co(co8), .ovf(ovf8)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub_v[1]),
    .a(a_v[1][0:0]), .b(b_v[1][0:0]), .ci(ci_v[1]),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1), .ovf(ovf1)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub_v[2]),
    .a(a_v[2][15:0]), .b(b_v[2][15:0]), .ci(ci_v[2]),
    .busy(busy16), .done(done16), .sum(sum16), .co(co16), .ovf(ovf16)
  );

  always_comb begin
    busy_o[0] = busy8;  done_o[0] = done8;  co_o[0] = co8;  ovf_o[0] = ovf8;  sum_o[0] = 32'(sum8);
    busy_o[1] = busy1;  done_o[1] = done1;  co_o[1] = co1;  ovf_o[1] = ovf1;  sum_o[1] = 32'(sum1);
    busy_o[2] = busy16; done_o[2] = done16; co_o[2] = co16; ovf_o[2] = ovf16; sum_o[2] = 32'(sum16);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int widthOf(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 1 : 16);
  endfunction

  // Reference: unsigned sum/difference for sum and co, signed range test for ovf
  function automatic exp_t refModel(input int w, input logic sub, input logic [31:0] a,
                                    input logic [31:0] b, input logic ci);
    exp_t   e;
    longint m  = longint'(1) << w;
    longint ua = longint'(a) & (m - 1);
    longint ub = longint'(b) & (m - 1);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    longint raw, sres;
    if (sub) begin
      raw  = ua - ub;
      e.co = (ua >= ub);
      sres = sa - sb;
    end else begin
      raw  = ua + ub + longint'(ci);
      e.co = (raw >= m);
      sres = sa + sb + longint'(ci);
    end
    e.sum = 32'(raw & (m - 1));
    e.ovf = (sres < -(m / 2)) || (sres > (m / 2 - 1));
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic failNote(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s", name);
  endtask

  function automatic void pushExp(input int k, input exp_t e);
    case (k)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endfunction

  task automatic popExp(input int k, output exp_t e, output bit ok);
    ok = 1'b1;
    e  = '{sum: 32'd0, co: 1'b0, ovf: 1'b0};
    case (k)
      0:       if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
      1:       if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // Wait for a negedge where the DUT can accept, then present start for one cycle
  task automatic applyStimulus(input int k, input logic sub, input logic [31:0] a,
                               input logic [31:0] b, input logic ci);
    int waited = 0;
    @(negedge clk);
    while (busy_o[k] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      failNote("accept_timeout");
      return;
    end
    sub_v[k]   = sub;
    a_v[k]     = a;
    b_v[k]     = b;
    ci_v[k]    = ci;
    start_v[k] = 1'b1;
    pushExp(k, refModel(widthOf(k), sub, a, b, ci));
    @(negedge clk);
    start_v[k] = 1'b0;
  endtask

  task automatic randomRun(input int k);
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus(k, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  // Monitor: pops on every done pulse; between pulses the result must hold
  initial begin
    logic [31:0] last_sum [3];
    int          busy_run [3];
    logic        prev_done[3];
    exp_t        e;
    bit          ok;
    for (int k = 0; k < 3; k++) begin
      last_sum[k] = '0; busy_run[k] = 0; prev_done[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          last_sum[k] = '0; busy_run[k] = 0; prev_done[k] = 1'b0;
        end else begin
          if (busy_o[k]) busy_run[k]++;
          if (done_o[k]) begin
            popExp(k, e, ok);
            if (!ok) begin
              failNote($sformatf("unexpected_done w%0d", widthOf(k)));
            end else begin
              checkOutput($sformatf("sum w%0d", widthOf(k)), sum_o[k], e.sum);
              checkOutput($sformatf("co w%0d", widthOf(k)), 32'(co_o[k]), 32'(e.co));
              checkOutput($sformatf("ovf w%0d", widthOf(k)), 32'(ovf_o[k]), 32'(e.ovf));
              checkOutput($sformatf("busy_cycles w%0d", widthOf(k)), 32'(busy_run[k]), 32'(widthOf(k)));
              checkOutput($sformatf("done_pulse w%0d", widthOf(k)), 32'(prev_done[k]), 32'd0);
            end
            last_sum[k] = sum_o[k];
            busy_run[k] = 0;
          end else begin
            checkOutput($sformatf("sum_hold w%0d", widthOf(k)), sum_o[k], last_sum[k]);
          end
          prev_done[k] = done_o[k];
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      start_v[k] = 1'b0; sub_v[k] = 1'b0; ci_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0;
    end

    // Reset state
    #2;
    checkOutput("rst_busy", 32'(busy8), 32'd0);
    checkOutput("rst_done", 32'(done8), 32'd0);
    checkOutput("rst_sum", 32'(sum8), 32'd0);
    checkOutput("rst_co", 32'(co8), 32'd0);
    checkOutput("rst_ovf", 32'(ovf8), 32'd0);
    #21 rst_n = 1'b1;
    $display("[TB] reset released");

    // Directed cases on the 8-bit instance
    applyStimulus(0, 1'b0, 32'hFF, 32'h01, 1'b0);
    applyStimulus(0, 1'b0, 32'h5A, 32'hA5, 1'b1);
    applyStimulus(0, 1'b0, 32'h7F, 32'h01, 1'b0);
    applyStimulus(0, 1'b1, 32'h10, 32'h01, 1'b1);
    applyStimulus(0, 1'b1, 32'h00, 32'h01, 1'b0);

    // A start pulse mid-operation must be ignored
    applyStimulus(0, 1'b0, 32'h12, 32'h34, 1'b0);
    repeat (3) @(negedge clk);
    sub_v[0] = 1'b1; a_v[0] = 32'hAA; b_v[0] = 32'h55; start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    // The next call lands on the DONE cycle, exercising back-to-back accepts
    applyStimulus(0, 1'b0, 32'h80, 32'h80, 1'b0);
    applyStimulus(0, 1'b1, 32'h80, 32'h01, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(0, 1'b0, 32'h01, 32'h02, 1'b1);
    applyStimulus(1, 1'b0, 32'h0, 32'h0, 1'b1);
    applyStimulus(1, 1'b1, 32'h0, 32'h1, 1'b0);

    t = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end

    // Asynchronous reset in the middle of an operation
    applyStimulus(0, 1'b0, 32'h55, 32'h0F, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy8), 32'd0);
    checkOutput("abort_done", 32'(done8), 32'd0);
    checkOutput("abort_sum", 32'(sum8), 32'd0);
    checkOutput("abort_co", 32'(co8), 32'd0);
    checkOutput("abort_ovf", 32'(ovf8), 32'd0);
    q0.delete(); q1.delete(); q2.delete();
    #9 rst_n = 1'b1;
    applyStimulus(0, 1'b0, 32'h03, 32'h04, 1'b0);

    // Randomized traffic on all three widths concurrently
    fork
      randomRun(0);
      randomRun(1);
      randomRun(2);
    join

    t = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if ((q0.size() + q1.size() + q2.size()) > 0) failNote("drain_timeout");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract controller that time-shares one instance of the team's 1-bit full_adder cell (ports a, b, ci, s, co) to add or subtract two WIDTH-bit operands, LSB first, one bit per clock. A start/busy/done handshake sequences the operation. The block holds the carry flip-flop, the operand and result shift registers, and the bit counter. It is the next step after exhaustive checking of the combinational cell: a multi-cycle datapath built around that cell.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
clk  input  1  single system clock, rising-edge active
rst_n  input  1  reset, asynchronous assert, active-low; all state clears immediately
start  input  1  one-cycle request; sampled only in IDLE or DONE
sub  input  1  0 = a+b+ci, 1 = a-b (b inverted, carry-in forced 1, ci ignored); sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
ci  input  1  carry-in for add; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse when sum/co/ovf become valid
sum  output  WIDTH  result; holds until the next accepted start
co  output  1  final carry-out (for sub: 1 = no borrow)
ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- One clock domain; reset is asynchronous and active-low; rst_n=0 forces state IDLE, busy=0, done=0, sum=0, co=0, ovf=0, counter=0, carry=0, shift registers=0.
- States:
  - IDLE: start=1 -> RUN.
  - RUN: counter reaches WIDTH-1 -> DONE.
  - DONE (exactly one cycle): start=1 -> RUN, otherwise -> IDLE.
- Accept edge (start=1 in IDLE/DONE):
  - Load opA<=a, opB<=(sub ? ~b : b), carry<=(sub ? 1 : ci), counter<=0.
  - sum, co and ovf are not cleared at accept; they update only on the final RUN edge.
- RUN, each edge:
  - full_adder inputs: a=opA[0], b=opB[0], ci=carry.
  - opA and opB shift right by one.
  - The result shift register shifts right with s entering at the MSB.
  - carry<=co; counter increments.
  - On the edge with counter==WIDTH-1: sum<=the completed result, co<=adder co, ovf<=carry XOR adder co (carry here is the carry into the MSB).
- Latency: accept at edge E0; busy=1 from E0 through EW; done=1 and results valid for the cycle after EW (WIDTH+1 edges after the accept). done is low in every other state.
- start while busy=1 is ignored; there is no queuing.
- start in DONE: accepted. done still pulses for that cycle, then busy rises at the next edge (back-to-back ops, WIDTH+1 cycles each).
- WIDTH=1: a single RUN cycle; ovf=carry-in XOR co.
- Reset mid-RUN aborts the operation: outputs return to reset values and no done pulse is issued.
- Arithmetic is modulo 2^WIDTH; sum, co and ovf must match a+b+ci (or a-b) computed at WIDTH+1 bits.

Test Plan:
1. Add wrap: WIDTH=8, a=0xFF, b=0x01, ci=0, sub=0 -> done exactly 9 edges after accept; sum=0x00, co=1, ovf=0; busy high for 8 cycles.
2. Add with carry-in: a=0x5A, b=0xA5, ci=1 -> sum=0x00, co=1, ovf=0. Signed overflow case: a=0x7F, b=0x01, ci=0 -> sum=0x80, co=0, ovf=1.
3. Subtract: sub=1, a=0x10, b=0x01, ci=1 (must be ignored) -> sum=0x0F, co=1, ovf=0. Borrow case: a=0x00, b=0x01 -> sum=0xFF, co=0, ovf=0.
4. Handshake: pulse start mid-RUN with different operands -> ignored, first result unchanged. Assert start during the DONE cycle -> new op accepted, done pulses once per op, sum holds between ops.
5. Reset mid-op: drop rst_n asynchronously (not clock-aligned) at bit 4 -> busy, done, sum, co and ovf are 0 immediately. After release, a fresh op (0x03+0x04) returns sum=0x07.
6. Random: 1000 random a/b/ci/sub with random idle gaps, checked against the reference arithmetic; repeat at WIDTH=1 and WIDTH=16.
